// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared CPU constants: opcodes, control bundle layout
package id_ex_stage_pkg;

    localparam int CTRL_W = 13;

    // Control bundle bit positions:
    // {RegDst[1:0],Jump,Branch,BranchType,MemRead,MemtoReg[1:0],MemWrite,ALUSrc,RegWrite,ALUOp[1:0]}
    localparam int CTRL_REGDST_HI   = 12;
    localparam int CTRL_REGDST_LO   = 11;
    localparam int CTRL_JUMP        = 10;
    localparam int CTRL_BRANCH      = 9;
    localparam int CTRL_BRANCHTYPE  = 8;
    localparam int CTRL_MEMREAD     = 7;
    localparam int CTRL_MEMTOREG_HI = 6;
    localparam int CTRL_MEMTOREG_LO = 5;
    localparam int CTRL_MEMWRITE    = 4;
    localparam int CTRL_ALUSRC      = 3;
    localparam int CTRL_REGWRITE    = 2;
    localparam int CTRL_ALUOP_HI    = 1;
    localparam int CTRL_ALUOP_LO    = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX pipeline register bus: decode inputs, EX outputs, hazard status
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int C_W    = CTRL_W
);
    logic [C_W-1:0]    IDCtrl;
    logic [DATA_W-1:0] IDPCPlus4, IDReadData1, IDReadData2, IDSignImm;
    logic [4:0]        IDRs, IDRt, IDRd;
    logic              IDUsesRt;
    logic              Flush;
    logic              HoldEX;

    logic [C_W-1:0]    EXCtrl;
    logic [DATA_W-1:0] EXPCPlus4, EXReadData1, EXReadData2, EXSignImm;
    logic [4:0]        EXRs, EXRt, EXRd;
    logic              EXValid;
    logic              HazardStall;
    logic [15:0]       BubbleCount;

    modport master (
        output IDCtrl, IDPCPlus4, IDReadData1, IDReadData2, IDSignImm,
               IDRs, IDRt, IDRd, IDUsesRt, Flush, HoldEX,
        input  EXCtrl, EXPCPlus4, EXReadData1, EXReadData2, EXSignImm,
               EXRs, EXRt, EXRd, EXValid, HazardStall, BubbleCount
    );

    modport slave (
        input  IDCtrl, IDPCPlus4, IDReadData1, IDReadData2, IDSignImm,
               IDRs, IDRt, IDRd, IDUsesRt, Flush, HoldEX,
        output EXCtrl, EXPCPlus4, EXReadData1, EXReadData2, EXSignImm,
               EXRs, EXRt, EXRd, EXValid, HazardStall, BubbleCount
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use comparator between the load in EX and the instruction in ID
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);
    // $zero never carries a dependency, and a bubble in EX masks the hazard
    assign lu = ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flush, hold, load-use bubble insertion
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int C_W    = CTRL_W
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    logic [C_W-1:0]    ex_ctrl;
    logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_valid;
    logic [15:0]       bubble_cnt;
    logic              lu;

    hazard_detect u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt       (ex_rt),
        .id_rs       (bus.IDRs),
        .id_rt       (bus.IDRt),
        .id_uses_rt  (bus.IDUsesRt),
        .lu          (lu)
    );

    // Flush outranks the stall: the dependent instruction dies anyway
    assign bus.HazardStall = lu & ~bus.Flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl    <= '0;
            ex_pc4     <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_valid   <= 1'b0;
            bubble_cnt <= '0;
        end else if (bus.Flush) begin
            ex_ctrl    <= '0;
            ex_pc4     <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_valid   <= 1'b0;
            bubble_cnt <= sat_inc16(bubble_cnt);
        end else if (!bus.HoldEX) begin
            // On load-use only control and valid are zeroed; datapath content is don't-care
            ex_ctrl    <= lu ? '0 : bus.IDCtrl;
            ex_valid   <= ~lu;
            ex_pc4     <= bus.IDPCPlus4;
            ex_rd1     <= bus.IDReadData1;
            ex_rd2     <= bus.IDReadData2;
            ex_imm     <= bus.IDSignImm;
            ex_rs      <= bus.IDRs;
            ex_rt      <= bus.IDRt;
            ex_rd      <= bus.IDRd;
            if (lu)
                bubble_cnt <= sat_inc16(bubble_cnt);
        end
    end

    assign bus.EXCtrl      = ex_ctrl;
    assign bus.EXPCPlus4   = ex_pc4;
    assign bus.EXReadData1 = ex_rd1;
    assign bus.EXReadData2 = ex_rd2;
    assign bus.EXSignImm   = ex_imm;
    assign bus.EXRs        = ex_rs;
    assign bus.EXRt        = ex_rt;
    assign bus.EXRd        = ex_rd;
    assign bus.EXValid     = ex_valid;
    assign bus.BubbleCount = bubble_cnt;
endmodule
